// File: rtl/phase_scheduler.sv
// phase_scheduler
//   Chooses the next intersection phase and hands it to the display/timer
//   datapath. Vehicle approaches with demand are served round-robin. A latched
//   pedestrian request is inserted between vehicle phases. Emergency requests
//   preempt whatever phase is running.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-low
//   stop             freeze: state, counters and outputs hold (ped latch still runs)
//   veh_req[3:0]     level vehicle demand, [0]=N [1]=E [2]=S [3]=W
//   ped_req          pedestrian button, any width
//   em_req, em_dir   emergency request (level) and its approach
//   TGn/TGe/TGs/TGw  green time per approach, 0 disables the approach
//   TP               pedestrian walk time
//   phase_done       datapath pulse: granted phase has finished
//   phase_start      pulse: phase_sel/phase_time carry a new grant
//   phase_abort      pulse: datapath must terminate the running phase
//   phase_sel        0-3 approach, 4 pedestrian, 7 all-red/none
//   phase_time       captured time of the granted phase (all ones = emergency)
//   ped_pending      pedestrian request latched, not yet served
//   em_active        running phase is an emergency hold
//   state            0 IDLE, 1 CLEAR, 2 GRANT, 3 RUN
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no demand; all-red
// CLEAR | all-red clearance, ALL_RED cycles, then decide or go idle
// GRANT | decision cycle; issues phase_start on the way to RUN
// RUN   | phase owned by the datapath until done/abort

module phase_scheduler #(
  parameter int TW      = 8,
  parameter int ALL_RED = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stop,
  input  logic [3:0]    veh_req,
  input  logic          ped_req,
  input  logic          em_req,
  input  logic [1:0]    em_dir,
  input  logic [TW-1:0] TGn,
  input  logic [TW-1:0] TGe,
  input  logic [TW-1:0] TGs,
  input  logic [TW-1:0] TGw,
  input  logic [TW-1:0] TP,
  input  logic          phase_done,
  output logic          phase_start,
  output logic          phase_abort,
  output logic [2:0]    phase_sel,
  output logic [TW-1:0] phase_time,
  output logic          ped_pending,
  output logic          em_active,
  output logic [1:0]    state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] GRANT = 2'd2;
  localparam logic [1:0] RUN   = 2'd3;

  localparam logic [2:0] SEL_PED  = 3'd4;
  localparam logic [2:0] SEL_NONE = 3'd7;

  localparam int CW = (ALL_RED > 1) ? $clog2(ALL_RED) : 1;
  localparam logic [CW-1:0] CLR_LOAD = CW'(ALL_RED - 1);

  logic [TW-1:0] tg [4];
  logic [3:0]    elig;
  logic          any_elig;
  logic          demand;
  logic [1:0]    rr_ptr;
  logic          last_ped;
  logic [CW-1:0] clr_cnt;
  logic          vh_found;
  logic [1:0]    vh_idx;
  logic [1:0]    cand;
  logic          ped_take;
  logic          ped_clr;
  logic          em_mismatch;

  assign tg[0] = TGn;
  assign tg[1] = TGe;
  assign tg[2] = TGs;
  assign tg[3] = TGw;

  always_comb begin
    elig = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      elig[i] = veh_req[i] && (tg[i] != '0);
    end
  end

  assign any_elig = |elig;
  assign demand   = any_elig | ped_pending | em_req;

  // first eligible approach after the last served one
  always_comb begin
    vh_found = 1'b0;
    vh_idx   = 2'd0;
    cand     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!vh_found && elig[cand]) begin
        vh_found = 1'b1;
        vh_idx   = cand;
      end
    end
  end

  // back-to-back pedestrian phases are skipped while vehicles wait
  assign ped_take    = ped_pending && !(last_ped && any_elig);
  assign ped_clr     = (state == GRANT) && !stop && !em_req && ped_take;
  assign em_mismatch = ({1'b0, em_dir} != phase_sel);

  // a press in the same cycle as the grant survives the clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped_pending <= 1'b0;
    end else begin
      ped_pending <= (ped_pending & ~ped_clr) | ped_req;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      phase_sel   <= SEL_NONE;
      phase_time  <= '0;
      phase_start <= 1'b0;
      phase_abort <= 1'b0;
      em_active   <= 1'b0;
      rr_ptr      <= 2'd3;
      last_ped    <= 1'b0;
      clr_cnt     <= '0;
    end else begin
      phase_start <= 1'b0;
      phase_abort <= 1'b0;
      if (!stop) begin
        case (state)
          IDLE: begin
            if (demand) state <= GRANT;
          end

          GRANT: begin
            if (em_req) begin
              phase_sel   <= {1'b0, em_dir};
              phase_time  <= '1;
              em_active   <= 1'b1;
              last_ped    <= 1'b0;
              phase_start <= 1'b1;
              state       <= RUN;
            end else if (ped_take) begin
              phase_sel   <= SEL_PED;
              phase_time  <= TP;
              last_ped    <= 1'b1;
              phase_start <= 1'b1;
              state       <= RUN;
            end else if (vh_found) begin
              phase_sel   <= {1'b0, vh_idx};
              phase_time  <= tg[vh_idx];
              rr_ptr      <= vh_idx;
              last_ped    <= 1'b0;
              phase_start <= 1'b1;
              state       <= RUN;
            end else begin
              phase_sel <= SEL_NONE;
              state     <= IDLE;
            end
          end

          RUN: begin
            if (em_active) begin
              // hold ends when the request drops or moves to another approach
              if (!em_req || em_mismatch) begin
                phase_abort <= 1'b1;
                em_active   <= 1'b0;
                phase_sel   <= SEL_NONE;
                clr_cnt     <= CLR_LOAD;
                state       <= CLEAR;
              end
            end else if (em_req) begin
              if (em_mismatch) begin
                phase_abort <= 1'b1;
                phase_sel   <= SEL_NONE;
                clr_cnt     <= CLR_LOAD;
                state       <= CLEAR;
              end else begin
                // emergency already has green: convert to a hold in place
                em_active <= 1'b1;
              end
            end else if (phase_done) begin
              phase_sel <= SEL_NONE;
              clr_cnt   <= CLR_LOAD;
              state     <= CLEAR;
            end
          end

          CLEAR: begin
            if (clr_cnt == '0) begin
              state <= demand ? GRANT : IDLE;
            end else begin
              clr_cnt <= clr_cnt - CW'(1);
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_scheduler.sv
module tb_phase_scheduler;
  localparam int TW      = 8;
  localparam int ALL_RED = 2;

  logic          clk = 1'b0;
  logic          reset, stop, ped_req, em_req, phase_done;
  logic [3:0]    veh_req;
  logic [1:0]    em_dir;
  logic [TW-1:0] TGn, TGe, TGs, TGw, TP;
  logic          phase_start, phase_abort, ped_pending, em_active;
  logic [2:0]    phase_sel;
  logic [TW-1:0] phase_time;
  logic [1:0]    state;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: round-robin pointer, latched ped request, previous grant kind
  int m_rr       = 3;
  bit m_ped      = 1'b0;
  bit m_last_ped = 1'b0;
  int m_time     = 0;

  phase_scheduler #(.TW(TW), .ALL_RED(ALL_RED)) dut (
    .clk(clk), .reset(reset), .stop(stop), .veh_req(veh_req), .ped_req(ped_req),
    .em_req(em_req), .em_dir(em_dir), .TGn(TGn), .TGe(TGe), .TGs(TGs), .TGw(TGw),
    .TP(TP), .phase_done(phase_done), .phase_start(phase_start),
    .phase_abort(phase_abort), .phase_sel(phase_sel), .phase_time(phase_time),
    .ped_pending(ped_pending), .em_active(em_active), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kind: 0 none, 1 emergency, 2 pedestrian, 3 vehicle
  function automatic void predict(output int sel, output int tm, output int kind);
    int tgv [4];
    bit el [4];
    bit any_el;
    int idx;
    tgv[0] = int'(TGn); tgv[1] = int'(TGe); tgv[2] = int'(TGs); tgv[3] = int'(TGw);
    any_el = 1'b0;
    for (int i = 0; i < 4; i++) begin
      el[i]  = veh_req[i] && (tgv[i] != 0);
      any_el = any_el | el[i];
    end
    sel = 7; tm = 0; kind = 0;
    if (em_req) begin
      sel = int'(em_dir); tm = (1 << TW) - 1; kind = 1;
    end else if (m_ped && !(m_last_ped && any_el)) begin
      sel = 4; tm = int'(TP); kind = 2;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = (m_rr + k) % 4;
        if (kind == 0 && el[idx]) begin
          sel = idx; tm = tgv[idx]; kind = 3;
        end
      end
    end
  endfunction

  task automatic expect_grant(input string tag, output int cyc);
    int sel, tm, kind;
    predict(sel, tm, kind);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!phase_start && cyc < 64);
    chk({tag, "_start"}, 32'(phase_start), 32'd1);
    chk({tag, "_sel"}, 32'(phase_sel), 32'(sel));
    chk({tag, "_time"}, 32'(phase_time), 32'(tm));
    chk({tag, "_em"}, 32'(em_active), 32'(kind == 1));
    if (kind == 2) begin
      m_ped = 1'b0; m_last_ped = 1'b1;
    end else if (kind == 3) begin
      m_rr = sel; m_last_ped = 1'b0;
    end else if (kind == 1) begin
      m_last_ped = 1'b0;
    end
    m_time = tm;
    chk({tag, "_pedp"}, 32'(ped_pending), 32'(m_ped));
  endtask

  task automatic finish_phase(input int hold);
    tick(hold);
    phase_done = 1'b1;
    tick(1);
    phase_done = 1'b0;
  endtask

  initial begin
    int cyc;
    int seq [5];
    bit flag;
    logic [3:0] nz;
    seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 0;

    reset = 1'b0; stop = 1'b0; ped_req = 1'b0; em_req = 1'b0; em_dir = 2'd0;
    phase_done = 1'b0; veh_req = 4'b0000;
    TGn = '0; TGe = '0; TGs = '0; TGw = '0; TP = '0;
    tick(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_sel", 32'(phase_sel), 32'd7);
    chk("rst_time", 32'(phase_time), 32'd0);
    chk("rst_pulses", 32'({phase_start, phase_abort}), 32'd0);
    chk("rst_flags", 32'({ped_pending, em_active}), 32'd0);

    // round robin over all four approaches
    reset = 1'b1;
    veh_req = 4'b1111; TGn = 8'd5; TGe = 8'd10; TGs = 8'd5; TGw = 8'd5; TP = 8'd3;
    expect_grant("t1_g0", cyc);
    chk("t1_latency", 32'(cyc), 32'd2);
    chk("t1_seq0", 32'(phase_sel), 32'(seq[0]));
    for (int i = 1; i < 5; i++) begin
      finish_phase(2 + i);
      chk("t1_clear_sel", 32'(phase_sel), 32'd7);
      chk("t1_clear_state", 32'(state), 32'd1);
      expect_grant("t1_g", cyc);
      chk("t1_gap", 32'(cyc), 32'(ALL_RED + 1));
      chk("t1_seq", 32'(phase_sel), 32'(seq[i]));
    end
    TGn = 8'd9;
    tick(1);
    chk("t1_time_captured", 32'(phase_time), 32'd5);
    TGn = 8'd5;

    // disabled and idle approaches are skipped
    veh_req = 4'b0101; TGs = 8'd0;
    for (int i = 0; i < 3; i++) begin
      finish_phase(2);
      expect_grant("t2_g", cyc);
      chk("t2_only_n", 32'(phase_sel), 32'd0);
    end

    // pedestrian insertion and alternation
    veh_req = 4'b1111; TGs = 8'd5; TP = 8'd3;
    ped_req = 1'b1; tick(1); ped_req = 1'b0; m_ped = 1'b1;
    chk("t3_latched", 32'(ped_pending), 32'd1);
    finish_phase(2);
    expect_grant("t3_ped1", cyc);
    chk("t3_ped1_sel", 32'(phase_sel), 32'd4);
    ped_req = 1'b1; tick(1); ped_req = 1'b0; m_ped = 1'b1;
    finish_phase(2);
    expect_grant("t3_e", cyc);
    chk("t3_e_sel", 32'(phase_sel), 32'd1);
    finish_phase(2);
    expect_grant("t3_ped2", cyc);
    chk("t3_ped2_sel", 32'(phase_sel), 32'd4);
    finish_phase(2);
    expect_grant("t3_s", cyc);
    chk("t3_s_sel", 32'(phase_sel), 32'd2);

    // emergency preemption on another approach, then resume
    veh_req = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      finish_phase(2);
      expect_grant("t4_pre", cyc);
    end
    chk("t4_at_e", 32'(phase_sel), 32'd1);
    em_req = 1'b1; em_dir = 2'd2;
    tick(1);
    chk("t4_abort", 32'(phase_abort), 32'd1);
    chk("t4_abort_state", 32'(state), 32'd1);
    chk("t4_abort_sel", 32'(phase_sel), 32'd7);
    expect_grant("t4_em", cyc);
    chk("t4_em_sel", 32'(phase_sel), 32'd2);
    finish_phase(3);
    chk("t4_done_ignored", 32'({state, em_active}), 32'({2'd3, 1'b1}));
    em_req = 1'b0;
    tick(1);
    chk("t4_end_abort", 32'({phase_abort, em_active, state}), 32'({1'b1, 1'b0, 2'd1}));
    expect_grant("t4_resume", cyc);
    chk("t4_resume_w", 32'(phase_sel), 32'd3);
    // emergency on the running approach: hold in place, then direction change
    em_req = 1'b1; em_dir = 2'd3;
    tick(1);
    chk("t4_same_noabort", 32'(phase_abort), 32'd0);
    chk("t4_same_hold", 32'({em_active, state, phase_sel}), 32'({1'b1, 2'd3, 3'd3}));
    em_dir = 2'd0;
    tick(1);
    chk("t4_dirchg_abort", 32'({phase_abort, state}), 32'({1'b1, 2'd1}));
    expect_grant("t4_em2", cyc);
    em_req = 1'b0;
    tick(1);
    chk("t4_em2_abort", 32'(phase_abort), 32'd1);
    expect_grant("t4_after", cyc);

    // freeze with a pedestrian press and a stray done
    stop = 1'b1; ped_req = 1'b1;
    tick(1);
    ped_req = 1'b0; m_ped = 1'b1; phase_done = 1'b1;
    tick(1);
    phase_done = 1'b0;
    flag = 1'b0;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (phase_start || phase_abort) flag = 1'b1;
      if (state != 2'd3 || phase_sel != 3'd0) cyc++;
    end
    chk("t5_no_pulses", 32'(flag), 32'd0);
    chk("t5_frozen", 32'(cyc), 32'd0);
    chk("t5_ped_latched", 32'(ped_pending), 32'd1);
    stop = 1'b0;
    tick(2);
    chk("t5_resume_run", 32'({state, phase_sel}), 32'({2'd3, 3'd0}));
    finish_phase(2);
    expect_grant("t5_ped", cyc);

    // randomized traffic
    for (int r = 0; r < 24; r++) begin
      veh_req = 4'($urandom);
      TGn = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      TGe = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      TGs = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      TGw = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      TP  = 8'($urandom_range(1, 255));
      nz = {TGw != 0, TGs != 0, TGe != 0, TGn != 0};
      if ((veh_req & nz) == 4'b0000) begin
        veh_req[0] = 1'b1;
        TGn = 8'($urandom_range(1, 255));
      end
      tick(1);
      chk("rnd_time_held", 32'(phase_time), 32'(m_time));
      if ($urandom_range(0, 2) == 0) begin
        ped_req = 1'b1; tick(1); ped_req = 1'b0; m_ped = 1'b1;
      end
      finish_phase($urandom_range(1, 4));
      expect_grant("rnd", cyc);
    end

    // reset during GRANT
    finish_phase(2);
    for (int i = 0; i < 10 && state != 2'd2; i++) tick(1);
    chk("t6_in_grant", 32'(state), 32'd2);
    reset = 1'b0;
    #1;
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_sel", 32'(phase_sel), 32'd7);
    chk("t6_rst_time", 32'(phase_time), 32'd0);
    chk("t6_rst_flags", 32'({phase_start, phase_abort, ped_pending, em_active}), 32'd0);
    veh_req = 4'b0000;
    m_rr = 3; m_ped = 1'b0; m_last_ped = 1'b0;
    tick(2);
    reset = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (phase_start || state != 2'd0) flag = 1'b1;
    end
    chk("t6_stays_idle", 32'(flag), 32'd0);
    veh_req = 4'b0001; TGn = 8'd7;
    expect_grant("t6_first", cyc);
    chk("t6_latency", 32'(cyc), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
